// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, fault codes, FSM states
// and the access legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic is_illegal(input logic load, input logic store,
                                        input logic [2:0] f3);
        logic ld_ok;
        logic st_ok;
        ld_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
        st_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (load && store) || (load && !ld_ok) || (store && !st_ok);
    endfunction

    // f3[1:0] encodes the access size for every legal funct3 (00 byte, 01 half, 10 word).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side request/response signals and the data-memory port of the lsu.
interface lsu_if;

    logic        start;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata_out;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, load, store, funct3, addr, wdata, mem_ack, mem_rdata,
        output busy, done, rdata_out, fault,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output start, load, store, funct3, addr, wdata, mem_ack, mem_rdata,
        input  busy, done, rdata_out, fault,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication / strobe generation and
// load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wstrb_o = 4'b0000;
        st_wdata_o = st_wdata_i;
        case (st_funct3_i)
            F3_B: begin
                st_wstrb_o = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            F3_H: begin
                st_wstrb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            F3_W:    st_wstrb_o = 4'b1111;
            default: st_wstrb_o = 4'b0000;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    end

    always_comb begin
        ld_data_o = '0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            F3_W:    ld_data_o = ld_rdata_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-granular req/ack memory access per start, registered outputs.
// Optional macro LSU_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES cycles in REQ.
//
// state | meaning
// IDLE  | waiting for start; faults detected here skip straight to RESP
// REQ   | mem_req held with stable address/strobes/data until mem_ack
// RESP  | done pulse visible for one cycle, then back to IDLE
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    fault_e      fault_q, fault_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    lsu_align u_align (
        .st_funct3_i (bus.funct3),
        .st_off_i    (bus.addr[1:0]),
        .st_wdata_i  (bus.wdata),
        .st_wstrb_o  (st_wstrb),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (ld_f3_q),
        .ld_off_i    (ld_off_q),
        .ld_rdata_i  (bus.mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        ld_f3_d     = ld_f3_q;
        ld_off_d    = ld_off_q;
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.load || bus.store)) begin
                    rdata_d = '0;
                    if (is_illegal(bus.load, bus.store, bus.funct3)) begin
                        state_d = ST_RESP;
                        fault_d = FAULT_ILLEGAL;
                        done_d  = 1'b1;
                    end else if (is_misaligned(bus.funct3, bus.addr[1:0])) begin
                        state_d = ST_RESP;
                        fault_d = FAULT_MISALIGN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        fault_d     = FAULT_NONE;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.store;
                        mem_addr_d  = {bus.addr[31:2], 2'b00};
                        mem_wstrb_d = bus.store ? st_wstrb : 4'b0000;
                        mem_wdata_d = bus.store ? st_wdata : 32'h0;
                        ld_f3_d     = bus.funct3;
                        ld_off_d    = bus.addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_d   = TmoW'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            ST_REQ: begin
                // An ack in the last counted cycle is checked first, so it beats the timeout.
                if (bus.mem_ack) begin
                    state_d   = ST_RESP;
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = mem_we_q ? 32'h0 : ld_data;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    state_d   = ST_RESP;
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = 32'h0;
                    fault_d   = FAULT_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= FAULT_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            ld_f3_q     <= '0;
            ld_off_q    <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            ld_f3_q     <= ld_f3_d;
            ld_off_q    <= ld_off_d;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdata_out = rdata_q;
    assign bus.fault     = fault_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random accesses checked against an arithmetic reference model.
module tb_lsu;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fault(input logic ld, input logic st,
                                           input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        if (ld && st) return 2'b10;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
        if (st && f3 > 3'd2) return 2'b10;
        sz = 1 << f3[1:0];
        if ((a % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int unsigned sz;
        sz = m_size(f3);
        v  = rd >> (8 * (a % 4));
        if (sz < 4) begin
            v = v & ((32'h1 << (8 * sz)) - 32'h1);
            if (f3 < 3'd4 && v[8*sz-1]) v = v - (32'h1 << (8 * sz));
        end
        return v;
    endfunction

    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int dly, input bit poke);
        logic [1:0]  ef;
        logic [31:0] ed;
        ef = m_fault(ld, st, f3, a);
        ed = st ? 32'h0 : m_load(f3, a, rd);
        bus.start  = 1'b1;
        bus.load   = ld;
        bus.store  = st;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
        step();
        bus.start  = 1'b0;
        if (!ld && !st) begin
            check("ign_busy", 32'(bus.busy), 32'h0);
            check("ign_done", 32'(bus.done), 32'h0);
            check("ign_req", 32'(bus.mem_req), 32'h0);
            return;
        end
        if (ef != 2'b00) begin
            check("flt_done", 32'(bus.done), 32'h1);
            check("flt_code", 32'(bus.fault), 32'(ef));
            check("flt_req", 32'(bus.mem_req), 32'h0);
            check("flt_busy", 32'(bus.busy), 32'h0);
            step();
            check("flt_done_end", 32'(bus.done), 32'h0);
            check("flt_req_end", 32'(bus.mem_req), 32'h0);
            return;
        end
        check("req", 32'(bus.mem_req), 32'h1);
        check("busy", 32'(bus.busy), 32'h1);
        check("we", 32'(bus.mem_we), 32'(st));
        check("maddr", bus.mem_addr, {a[31:2], 2'b00});
        check("wstrb", 32'(bus.mem_wstrb), st ? 32'(m_wstrb(f3, a)) : 32'h0);
        if (st) check("mwdata", bus.mem_wdata, m_wdata(f3, wd));
        for (int i = 0; i < dly; i++) begin
            bus.mem_ack = 1'b0;
            if (poke) begin
                bus.start = 1'b1;
                bus.load  = 1'b1;
                bus.store = 1'b0;
                bus.funct3 = 3'd2;
                bus.addr  = $urandom & 32'hFFFF_FFFC;
            end
            step();
            bus.start = 1'b0;
            check("wait_req", 32'(bus.mem_req), 32'h1);
            check("wait_busy", 32'(bus.busy), 32'h1);
            check("wait_addr", bus.mem_addr, {a[31:2], 2'b00});
            check("wait_done", 32'(bus.done), 32'h0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        check("done", 32'(bus.done), 32'h1);
        check("done_busy", 32'(bus.busy), 32'h0);
        check("done_req", 32'(bus.mem_req), 32'h0);
        check("done_fault", 32'(bus.fault), 32'h0);
        check("rdata", bus.rdata_out, ed);
        step();
        check("done_end", 32'(bus.done), 32'h0);
        check("rdata_hold", bus.rdata_out, ed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ld, st;
        logic [2:0] f3;
        int r;
        bus.start = 0; bus.load = 0; bus.store = 0; bus.funct3 = 0;
        bus.addr = 0; bus.wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_rdata", bus.rdata_out, 32'h0);
        check("rst_fault", 32'(bus.fault), 32'h0);
        check("rst_req", 32'(bus.mem_req), 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        step();

        access(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1'b0);
        check("sb_vec", m_wdata(3'd0, 32'h0000_00A5), 32'hA5A5_A5A5);
        access(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0, 1'b0);
        access(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0, 1'b0);
        access(1'b1, 1'b0, 3'd1, 32'h0000_3002, 32'h0, 32'h8001_0000, 1, 1'b0);
        access(1'b1, 1'b0, 3'd2, 32'h0000_3002, 32'h0, 32'h0, 0, 1'b0);
        access(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 5, 1'b1);
        access(1'b0, 1'b1, 3'd1, 32'h0000_5002, 32'h1234_BEEF, 32'h0, 2, 1'b0);
        access(1'b0, 1'b1, 3'd2, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        access(1'b1, 1'b1, 3'd2, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b0);
        access(1'b1, 1'b0, 3'd3, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 1'b1, 3'd4, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 1'b0, 3'd2, 32'h0000_7000, 32'h0, 32'h0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 9));
            ld = (r == 1) || (r >= 2 && r <= 5);
            st = (r == 1) || (r >= 6);
            f3 = ($urandom_range(0, 9) < 7) ? (ld ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)))
                                              : 3'($urandom);
            access(ld, st, f3, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        // Reset during REQ: request drops and a later ack is ignored.
        bus.start = 1'b1; bus.load = 1'b1; bus.store = 1'b0;
        bus.funct3 = 3'd2; bus.addr = 32'h0000_8000;
        step();
        bus.start = 1'b0;
        check("rr_req", 32'(bus.mem_req), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_req_drop", 32'(bus.mem_req), 32'h0);
        check("rr_busy", 32'(bus.busy), 32'h0);
        bus.mem_ack = 1'b1;
        step();
        check("rr_ack_done", 32'(bus.done), 32'h0);
        step();
        bus.mem_ack = 1'b0;
        check("rr_ack_done2", 32'(bus.done), 32'h0);
        check("rr_ack_req", 32'(bus.mem_req), 32'h0);

        // No ack: with the timeout option the access aborts after TMO cycles.
        bus.start = 1'b1; bus.load = 1'b1; bus.store = 1'b0;
        bus.funct3 = 3'd2; bus.addr = 32'h0000_9000;
        step();
        bus.start = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < int'(TMO); i++) begin
            check("tmo_req", 32'(bus.mem_req), 32'h1);
            check("tmo_done_early", 32'(bus.done), 32'h0);
            step();
        end
        check("tmo_done", 32'(bus.done), 32'h1);
        check("tmo_fault", 32'(bus.fault), 32'h3);
        check("tmo_rdata", bus.rdata_out, 32'h0);
        check("tmo_req_drop", 32'(bus.mem_req), 32'h0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        step();
        bus.mem_ack = 1'b0;
        check("tmo_late_ack", 32'(bus.done), 32'h0);
        check("tmo_fault_hold", 32'(bus.fault), 32'h3);
`else
        for (int i = 0; i < 20; i++) begin
            check("nto_req", 32'(bus.mem_req), 32'h1);
            check("nto_done", 32'(bus.done), 32'h0);
            step();
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        step();
        bus.mem_ack = 1'b0;
        check("nto_ack_done", 32'(bus.done), 32'h1);
        check("nto_fault", 32'(bus.fault), 32'h0);
        check("nto_rdata", bus.rdata_out, 32'h1111_2222);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
